// File: rtl/isi_channel_ocm_param.sv
// isi_channel_ocm_param: ISI channel whose pulse-response taps are fetched from on-chip memory,
// followed by a saturating FIR over the incoming symbol stream.
module isi_channel_ocm_param #(
   parameter int PULSE_RESPONSE_LENGTH = 3,
   parameter int SIGNAL_RESOLUTION = 8,
   parameter int COEFF_WIDTH = 16,
   parameter int COEFF_FRAC = 8,
   parameter int MEM_WIDTH = 64,
   parameter int ADDR_WIDTH = 14,
   parameter int ADDR_STRIDE = 4,
   parameter int MEM_LATENCY = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic signed [SIGNAL_RESOLUTION-1:0] signal_in,
   input  logic signal_in_valid,
   output logic signed [SIGNAL_RESOLUTION-1:0] signal_out,
   output logic signal_out_valid,
   input  logic load_mem,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic done_wait,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic mem_rd,
   input  logic [MEM_WIDTH-1:0] mem_readdata
);
   localparam int CPW = MEM_WIDTH / COEFF_WIDTH;
   localparam int NUM_WORDS = (PULSE_RESPONSE_LENGTH + CPW - 1) / CPW;
   localparam int NT = NUM_WORDS * CPW;
   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam int PW = SIGNAL_RESOLUTION + COEFF_WIDTH;
   localparam int AW = PW + $clog2(PULSE_RESPONSE_LENGTH);
   localparam logic signed [AW-1:0] SMAX = AW'(2 ** (SIGNAL_RESOLUTION - 1) - 1);
   localparam logic signed [AW-1:0] SMIN = ~SMAX;

   typedef enum logic [1:0] {IDLE, FETCH, WAIT, RUN} state_t;
   state_t state, state_nx;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [CW-1:0] rd_cnt, cap_cnt;
   logic [MEM_LATENCY-1:0] rd_pipe;
   logic signed [COEFF_WIDTH-1:0] c [NT];
   logic signed [SIGNAL_RESOLUTION-1:0] x [PULSE_RESPONSE_LENGTH];
   logic signed [SIGNAL_RESOLUTION-1:0] xn [PULSE_RESPONSE_LENGTH];
   logic signed [AW-1:0] acc, sh;
   logic signed [SIGNAL_RESOLUTION-1:0] y_sat;
   logic load_go, in_acc, cap_fire, last_rd, last_cap;

   assign cap_fire = rd_pipe[MEM_LATENCY-1];
   assign last_rd = rd_cnt == CW'(NUM_WORDS - 1);
   assign last_cap = cap_fire && cap_cnt == CW'(NUM_WORDS - 1);
   assign load_go = load_mem && (state == IDLE || state == RUN);
   assign in_acc = signal_in_valid && state == RUN && !load_mem;
   assign mem_addr = mem_rd ? addr_q : '0;

   always_ff @(posedge clk) begin
      if (!rstn) state <= IDLE;
      else state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      mem_rd = 1'b0;
      done_wait = 1'b0;
      case (state)
         IDLE: state_nx = load_mem ? FETCH : IDLE;
         FETCH: begin
            mem_rd = 1'b1;
            state_nx = last_rd ? WAIT : FETCH;
         end
         WAIT: state_nx = last_cap ? RUN : WAIT;
         RUN: begin
            done_wait = 1'b1;
            state_nx = load_mem ? FETCH : RUN;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Full-precision MAC over the delay line as it will look after this sample shifts in
   always_comb begin
      acc = '0;
      xn[0] = signal_in;
      for (int k = 1; k < PULSE_RESPONSE_LENGTH; k++) xn[k] = x[k-1];
      for (int k = 0; k < PULSE_RESPONSE_LENGTH; k++) acc = acc + AW'(PW'(xn[k]) * PW'(c[k]));
      sh = acc >>> COEFF_FRAC;
      y_sat = sh > SMAX ? SMAX[SIGNAL_RESOLUTION-1:0] : sh < SMIN ? SMIN[SIGNAL_RESOLUTION-1:0] : sh[SIGNAL_RESOLUTION-1:0];
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         addr_q <= '0;
         rd_cnt <= '0;
         cap_cnt <= '0;
         rd_pipe <= '0;
         signal_out <= '0;
         signal_out_valid <= 1'b0;
         for (int k = 0; k < NT; k++) c[k] <= '0;
         for (int k = 0; k < PULSE_RESPONSE_LENGTH; k++) x[k] <= '0;
      end else begin
         rd_pipe <= (rd_pipe << 1) | MEM_LATENCY'(mem_rd);
         signal_out_valid <= in_acc;
         if (in_acc) signal_out <= y_sat;
         if (load_go) begin
            addr_q <= base_addr;
            rd_cnt <= '0;
            cap_cnt <= '0;
         end else begin
            if (mem_rd) begin
               addr_q <= addr_q + ADDR_WIDTH'(ADDR_STRIDE);
               rd_cnt <= rd_cnt + CW'(1);
            end
            if (cap_fire) cap_cnt <= cap_cnt + CW'(1);
         end
         // Padding lanes beyond the last tap are stored but never reach the MAC
         for (int k = 0; k < NT; k++) begin
            if (load_go) c[k] <= '0;
            else if (cap_fire && k / CPW == int'(cap_cnt)) c[k] <= mem_readdata[(k % CPW) * COEFF_WIDTH +: COEFF_WIDTH];
         end
         for (int k = 0; k < PULSE_RESPONSE_LENGTH; k++) begin
            if (load_go) x[k] <= '0;
            else if (in_acc) x[k] <= xn[k];
         end
      end
   end
endmodule

// File: tb/tb_isi_channel_ocm_param.sv
// tb_isi_channel_ocm_param: directed tests for the memory-loaded ISI channel
// (3-tap single-word instance and 5-tap two-word instance sharing stimulus).
module tb_isi_channel_ocm_param;
   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic signed [7:0] sin = '0;
   logic sin_v = 1'b0;
   logic load_mem = 1'b0;
   logic [13:0] base_addr = '0;
   logic signed [7:0] a_out, b_out;
   logic a_vld, b_vld, a_dw, b_dw, a_rd, b_rd;
   logic [13:0] a_addr, b_addr;
   logic [63:0] a_q1 = '0, b_q1 = '0, a_rdata = '0, b_rdata = '0;
   logic [63:0] mem [16384];
   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   isi_channel_ocm_param u_a (
      .clk(clk), .rstn(rstn), .signal_in(sin), .signal_in_valid(sin_v),
      .signal_out(a_out), .signal_out_valid(a_vld), .load_mem(load_mem),
      .base_addr(base_addr), .done_wait(a_dw), .mem_addr(a_addr),
      .mem_rd(a_rd), .mem_readdata(a_rdata)
   );

   isi_channel_ocm_param #(.PULSE_RESPONSE_LENGTH(5)) u_b (
      .clk(clk), .rstn(rstn), .signal_in(sin), .signal_in_valid(sin_v),
      .signal_out(b_out), .signal_out_valid(b_vld), .load_mem(load_mem),
      .base_addr(base_addr), .done_wait(b_dw), .mem_addr(b_addr),
      .mem_rd(b_rd), .mem_readdata(b_rdata)
   );

   // Two-cycle read latency memory
   always @(posedge clk) begin
      a_q1 <= mem[a_addr];
      a_rdata <= a_q1;
      b_q1 <= mem[b_addr];
      b_rdata <= b_q1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      sin = 8'sd5;
      sin_v = 1'b1;
      tick();
      tick();
      n_chk++;
      if ({a_out, a_vld, a_dw, a_rd, a_addr} !== '0 || {b_out, b_vld, b_dw, b_rd, b_addr} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs a=%h/%b/%b/%b/%h b=%h/%b/%b/%b/%h, required all 0", a_out, a_vld, a_dw, a_rd, a_addr, b_out, b_vld, b_dw, b_rd, b_addr);
      end
      rstn = 1'b1;
      tick();
      tick();
      n_chk++;
      if (a_vld !== 1'b0 || b_vld !== 1'b0 || a_dw !== 1'b0 || a_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ignores_input vld=%b/%b dw=%b rd=%b, required 0", a_vld, b_vld, a_dw, a_rd);
      end
      sin_v = 1'b0;
   endtask

   task automatic test_load_impulse;
      int ins [4] = '{64, 0, 0, 0};
      int exps [4] = '{64, 32, 16, 0};
      mem[0] = 64'h0000_0040_0080_0100;
      base_addr = 14'h0;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      n_chk++;
      if (a_rd !== 1'b1 || a_addr !== 14'h0) begin
         n_fail++;
         $display("FAIL load_read rd=%b addr=%h, required rd=1 addr=0000", a_rd, a_addr);
      end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_chk++;
         if (a_rd !== 1'b0 || a_dw !== (i == 3)) begin
            n_fail++;
            $display("FAIL load_timing cycle+%0d rd=%b dw=%b, required rd=0 dw=%b", i, a_rd, a_dw, i == 3);
         end
      end
      for (int i = 0; i < 8 && !b_dw; i++) tick();
      for (int i = 0; i < 4; i++) begin
         sin = 8'(ins[i]);
         sin_v = 1'b1;
         tick();
         n_chk++;
         if (a_vld !== 1'b1 || a_out !== exps[i]) begin
            n_fail++;
            $display("FAIL impulse[%0d] vld=%b out=%0d, required vld=1 out=%0d", i, a_vld, a_out, exps[i]);
         end
      end
      sin_v = 1'b0;
   endtask

   task automatic test_multi_word;
      int exps [5] = '{20, 0, 0, 0, 10};
      mem[14'h10] = 64'h0000_0000_0000_0100;
      mem[14'h14] = 64'h0000_0000_0000_0080;
      base_addr = 14'h10;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      n_chk++;
      if (b_rd !== 1'b1 || b_addr !== 14'h10) begin
         n_fail++;
         $display("FAIL multi_read0 rd=%b addr=%h, required rd=1 addr=0010", b_rd, b_addr);
      end
      tick();
      n_chk++;
      if (b_rd !== 1'b1 || b_addr !== 14'h14) begin
         n_fail++;
         $display("FAIL multi_read1 rd=%b addr=%h, required rd=1 addr=0014", b_rd, b_addr);
      end
      tick();
      n_chk++;
      if (b_rd !== 1'b0) begin
         n_fail++;
         $display("FAIL multi_read_count rd=%b, required 0", b_rd);
      end
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      n_chk++;
      if (b_dw !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_done timeout dw=%b, required 1", b_dw);
      end
      for (int i = 0; i < 5; i++) begin
         sin = (i == 0) ? 8'sd20 : 8'sd0;
         sin_v = 1'b1;
         tick();
         n_chk++;
         if (b_vld !== 1'b1 || b_out !== exps[i]) begin
            n_fail++;
            $display("FAIL multi_impulse[%0d] vld=%b out=%0d, required vld=1 out=%0d", i, b_vld, b_out, exps[i]);
         end
      end
      sin_v = 1'b0;
      sin = 8'sd99;
      tick();
      n_chk++;
      if (b_vld !== 1'b0 || b_out !== 8'sd10) begin
         n_fail++;
         $display("FAIL output_hold vld=%b out=%0d, required vld=0 out=10", b_vld, b_out);
      end
   endtask

   task automatic test_saturation;
      int ins [3] = '{100, -100, -1};
      int exps [3] = '{127, -128, -2};
      mem[14'h30] = 64'h0000_0000_0000_0200;
      base_addr = 14'h30;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      n_chk++;
      if (a_dw !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_done timeout dw=%b, required 1", a_dw);
      end
      for (int i = 0; i < 3; i++) begin
         sin = 8'(ins[i]);
         sin_v = 1'b1;
         tick();
         n_chk++;
         if (a_vld !== 1'b1 || a_out !== exps[i]) begin
            n_fail++;
            $display("FAIL saturate[%0d] vld=%b out=%0d, required vld=1 out=%0d", i, a_vld, a_out, exps[i]);
         end
      end
      sin_v = 1'b0;
   endtask

   task automatic test_reload;
      mem[14'h20] = 64'h0000_0000_0000_0300;
      base_addr = 14'h0;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      sin = 8'sd10;
      sin_v = 1'b1;
      tick();
      sin_v = 1'b0;
      base_addr = 14'h20;
      load_mem = 1'b1;
      n_chk++;
      if (a_vld !== 1'b1 || a_out !== 8'sd10) begin
         n_fail++;
         $display("FAIL reload_pending_out vld=%b out=%0d, required vld=1 out=10", a_vld, a_out);
      end
      tick();
      load_mem = 1'b0;
      n_chk++;
      if (a_dw !== 1'b0 || a_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL reload_dw_drop dw=%b vld=%b, required 0/0", a_dw, a_vld);
      end
      sin = 8'sd50;
      sin_v = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_chk++;
         if (a_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL reload_drop_input vld=%b, required 0", a_vld);
         end
         if (a_dw) break;
      end
      sin_v = 1'b0;
      n_chk++;
      if (a_dw !== 1'b1) begin
         n_fail++;
         $display("FAIL reload_done timeout dw=%b, required 1", a_dw);
      end
      for (int i = 0; i < 2; i++) begin
         sin = (i == 0) ? 8'sd10 : 8'sd0;
         sin_v = 1'b1;
         tick();
         n_chk++;
         if (a_vld !== 1'b1 || a_out !== ((i == 0) ? 8'sd30 : 8'sd0)) begin
            n_fail++;
            $display("FAIL reload_impulse[%0d] vld=%b out=%0d, required vld=1 out=%0d", i, a_vld, a_out, (i == 0) ? 30 : 0);
         end
      end
      sin_v = 1'b0;
   endtask

   task automatic test_reset_mid_fetch;
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      mem[14'h10] = 64'h7fff_7fff_7fff_7fff;
      mem[14'h14] = 64'h7fff_7fff_7fff_7fff;
      base_addr = 14'h10;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      tick();
      rstn = 1'b0;
      tick();
      n_chk++;
      if ({b_out, b_vld, b_dw, b_rd, b_addr} !== '0 || {a_out, a_vld, a_dw, a_rd, a_addr} !== '0) begin
         n_fail++;
         $display("FAIL midfetch_reset b=%h/%b/%b/%b/%h a=%h/%b/%b/%b/%h, required all 0", b_out, b_vld, b_dw, b_rd, b_addr, a_out, a_vld, a_dw, a_rd, a_addr);
      end
      rstn = 1'b1;
      sin = 8'sd7;
      sin_v = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_chk++;
         if ({a_vld, b_vld, a_dw, b_dw, a_rd, b_rd} !== 6'b0) begin
            n_fail++;
            $display("FAIL midfetch_idle vld=%b/%b dw=%b/%b rd=%b/%b, required 0", a_vld, b_vld, a_dw, b_dw, a_rd, b_rd);
         end
      end
      sin_v = 1'b0;
      mem[14'h40] = 64'h0000_0000_0000_0100;
      mem[14'h44] = 64'h0;
      base_addr = 14'h40;
      load_mem = 1'b1;
      tick();
      load_mem = 1'b0;
      n_chk++;
      if (b_rd !== 1'b1 || b_addr !== 14'h40 || a_rd !== 1'b1 || a_addr !== 14'h40) begin
         n_fail++;
         $display("FAIL post_reset_load rd=%b/%b addr=%h/%h, required 1/1 0040/0040", a_rd, b_rd, a_addr, b_addr);
      end
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      sin = 8'sd7;
      sin_v = 1'b1;
      tick();
      sin_v = 1'b0;
      n_chk++;
      if (a_vld !== 1'b1 || b_vld !== 1'b1 || a_out !== 8'sd7 || b_out !== 8'sd7) begin
         n_fail++;
         $display("FAIL post_reset_impulse vld=%b/%b out=%0d/%0d, required 1/1 7/7", a_vld, b_vld, a_out, b_out);
      end
   endtask

   task automatic test_simultaneous;
      int ra = 0;
      int rb = 0;
      for (int i = 0; i < 10 && !(a_dw && b_dw); i++) tick();
      base_addr = 14'h40;
      load_mem = 1'b1;
      sin = 8'sd9;
      sin_v = 1'b1;
      tick();
      sin_v = 1'b0;
      n_chk++;
      if (a_vld !== 1'b0 || b_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL simul_drop vld=%b/%b, required 0/0", a_vld, b_vld);
      end
      n_chk++;
      if (a_rd !== 1'b1 || b_rd !== 1'b1 || a_addr !== 14'h40) begin
         n_fail++;
         $display("FAIL simul_fetch rd=%b/%b addr=%h, required 1/1 0040", a_rd, b_rd, a_addr);
      end
      ra = int'(a_rd);
      rb = int'(b_rd);
      for (int i = 1; i <= 10; i++) begin
         load_mem = (i <= 3);
         tick();
         ra += int'(a_rd);
         rb += int'(b_rd);
      end
      load_mem = 1'b0;
      n_chk++;
      if (ra != 1 || rb != 2) begin
         n_fail++;
         $display("FAIL wait_load_ignored reads=%0d/%0d, required 1/2", ra, rb);
      end
      n_chk++;
      if (a_dw !== 1'b1 || b_dw !== 1'b1) begin
         n_fail++;
         $display("FAIL simul_done dw=%b/%b, required 1/1", a_dw, b_dw);
      end
      sin = -8'sd9;
      sin_v = 1'b1;
      tick();
      sin_v = 1'b0;
      n_chk++;
      if (a_vld !== 1'b1 || a_out !== -8'sd9 || b_out !== -8'sd9) begin
         n_fail++;
         $display("FAIL simul_after vld=%b out=%0d/%0d, required 1 -9/-9", a_vld, a_out, b_out);
      end
   endtask

   initial begin
      for (int i = 0; i < 16384; i++) mem[i] = '0;
      test_reset();
      test_load_impulse();
      test_multi_word();
      test_saturation();
      test_reload();
      test_reset_mid_fetch();
      test_simultaneous();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/isi_channel_ocm_param.md
Name: isi_channel_ocm_param

Overview:
Parametrised ISI channel model whose pulse-response taps are loaded from on-chip memory through a 64-bit (MEM_WIDTH) read port. The block drives the read addresses itself, captures packed coefficients after a fixed read latency, then convolves the incoming symbol stream with the loaded taps. The output is saturated. It sits between the PAM symbol generator and the receiver/equaliser. Taps can be reloaded at run time without a reset.

Parameters:
PULSE_RESPONSE_LENGTH, 3, number of taps (>=1)
SIGNAL_RESOLUTION, 8, signed sample width of signal_in and signal_out
COEFF_WIDTH, 16, signed tap width; MEM_WIDTH must be a multiple of it
COEFF_FRAC, 8, fractional bits of a tap (0x0100 = 1.0)
MEM_WIDTH, 64, memory read data width
ADDR_WIDTH, 14, memory address width
ADDR_STRIDE, 4, address increment between consecutive memory words
MEM_LATENCY, 2, cycles from mem_rd to valid mem_readdata (>=1)

Ports:
clk  input  1  system clock
rstn  input  1  synchronous active-low reset
signal_in  input  SIGNAL_RESOLUTION  signed input symbol
signal_in_valid  input  1  signal_in qualifier
signal_out  output  SIGNAL_RESOLUTION  signed channel output
signal_out_valid  output  1  signal_out qualifier
load_mem  input  1  pulse: start tap (re)load
base_addr  input  ADDR_WIDTH  first memory word address, latched on load_mem
done_wait  output  1  high while taps are loaded and the channel is running
mem_addr  output  ADDR_WIDTH  memory read address
mem_rd  output  1  memory read strobe
mem_readdata  input  MEM_WIDTH  memory read data

Behaviour:
- Reset: clk and rstn only; reset is synchronous, active-low.
  - Under reset, all outputs are 0, all taps are 0, the delay line is 0 and the state is IDLE.
  - Reset asserted in any state, including mid-fetch, aborts to IDLE. In-flight memory returns are discarded.
- Derived constants:
  - CPW = MEM_WIDTH/COEFF_WIDTH.
  - NUM_WORDS = ceil(PULSE_RESPONSE_LENGTH/CPW).
- States are IDLE, FETCH, WAIT and RUN.
- IDLE:
  - load_mem=1 latches base_addr, clears the tap array and delay line, and moves to FETCH.
  - signal_in_valid is ignored.
- FETCH:
  - Issues NUM_WORDS reads on consecutive cycles, with mem_rd=1.
  - mem_addr = base + i*ADDR_STRIDE for i = 0..NUM_WORDS-1. The address wraps modulo 2^ADDR_WIDTH.
  - Moves to WAIT after the last read is issued.
- Capture:
  - Word i is sampled exactly MEM_LATENCY cycles after its mem_rd.
  - Tap k = i*CPW+j takes bits [(j+1)*COEFF_WIDTH-1 : j*COEFF_WIDTH] of word i.
  - Lanes with k >= PULSE_RESPONSE_LENGTH are ignored.
- WAIT:
  - The cycle after the last capture, the block enters RUN.
  - done_wait rises in the same cycle as the RUN entry.
- RUN:
  - done_wait=1.
  - On signal_in_valid, the delay line shifts: x[0]=signal_in, x[k]=old x[k-1].
  - acc = sum over k of c[k]*x[k], full precision. Products are SIGNAL_RESOLUTION+COEFF_WIDTH bits. The accumulator adds clog2(PULSE_RESPONSE_LENGTH) guard bits.
  - Result = acc arithmetic-shifted right by COEFF_FRAC (truncation toward minus infinity).
  - The result saturates to [-2^(SR-1), 2^(SR-1)-1].
  - signal_out is registered. Latency is 1: signal_out_valid=1 exactly one cycle after each accepted signal_in_valid, otherwise 0.
  - signal_out holds its last value when not valid.
- Reload:
  - load_mem in RUN returns the block to FETCH with a new base_addr. done_wait drops on the next cycle.
  - The delay line and taps are cleared.
  - A result already in the output register is still presented with valid.
- Outside RUN:
  - signal_in_valid is dropped; no output valid is produced for it.
  - load_mem during FETCH or WAIT is ignored.
- Simultaneous load_mem and signal_in_valid in RUN: the reload wins and the sample is dropped.

Test Plan:
1. Basic load and impulse response.
   - Setup: defaults; memory[0x0000] = 0x0000_0040_0080_0100; base_addr=0; pulse load_mem.
   - Load response: a single mem_rd at addr 0; done_wait=1 exactly MEM_LATENCY+1 cycles after the read; taps are 1.0, 0.5, 0.25.
   - Stimulus: inputs 64, 0, 0, 0.
   - Required outputs: 64, 32, 16, 0, each 1 cycle after its input.
2. Multi-word fetch.
   - Setup: PULSE_RESPONSE_LENGTH=5; memory[0x10]=0x0000_0000_0000_0100, memory[0x14]=0x0000_0000_0000_0080; base_addr=0x10.
   - Required reads: addresses 0x10 then 0x14 on consecutive cycles.
   - Required taps: c0=1.0, c4=0.5, the rest 0.
   - Stimulus: impulse of 20. Required outputs: 20, 0, 0, 0, 10.
3. Saturation.
   - Setup: c0=0x0200 (2.0).
   - Input 100 -> output 127. Input -100 -> output -128. Input -1 -> output -2.
4. Run-time reload.
   - Setup: channel running with the scenario 1 taps; memory[0x20]=0x0000_0000_0000_0300; feed 10; then pulse load_mem with base 0x20.
   - Required: done_wait low during the reload; inputs fed during the reload produce no signal_out_valid.
   - After the reload, input 10 -> output 30, with no residual ISI from the old taps.
5. Reset mid-fetch.
   - Stimulus: assert rstn=0 one cycle after mem_rd.
   - Required: the next cycle has all outputs 0 and state IDLE.
   - Required: the delayed mem_readdata arriving later does not alter the taps, and inputs before the next load produce no output.
6. Simultaneous events.
   - Stimulus: load_mem and signal_in_valid asserted in the same RUN cycle.
   - Required: no signal_out_valid for that sample; FETCH starts the next cycle.
   - Stimulus: load_mem repeated during WAIT. Required: ignored, exactly NUM_WORDS reads issued.
